// File: rtl/p2s_arb_ctrl.sv
// ----------------------------------------------------------------------------
// p2s_arb_ctrl
//
// Two-requester round-robin front end for an NBITS-wide parallel-to-serial
// shifter. A winner's word is captured into word_reg. One LOAD cycle strobes
// the shifter and pulses the winner's grant. NBITS SEND cycles then shift the
// word out LSB first. GAP idle cycles follow before the next arbitration.
//
// Parameters
//   NBITS  word width and number of send cycles per word (>= 1)
//   GAP    idle cycles after each word (>= 0, 0 skips the gap state)
//
// Ports
//   clk       clock, rising edge
//   n_rst     asynchronous active-low reset
//   req0/din0 requester 0 request and word (word stable while req0 high)
//   req1/din1 requester 1 request and word (word stable while req1 high)
//   gnt0/gnt1 one-cycle acceptance pulses, issued in the LOAD cycle
//   p2s_din   word to the shifter (always word_reg)
//   p2s_load  shifter load strobe
//   p2s_send  shifter shift strobe / serial valid
//   owner     requester whose word is in flight (valid while busy)
//   busy      high in every state except IDLE
//   done      pulse on the final send cycle of a word
//
// Every output is either a register or a decode of registered state, so no
// request input reaches an output combinationally.
// ----------------------------------------------------------------------------
module p2s_arb_ctrl #(
    parameter int NBITS = 4,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             req0,
    input  logic [NBITS-1:0] din0,
    input  logic             req1,
    input  logic [NBITS-1:0] din1,
    output logic             gnt0,
    output logic             gnt1,
    output logic [NBITS-1:0] p2s_din,
    output logic             p2s_load,
    output logic             p2s_send,
    output logic             owner,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;
    localparam logic [1:0] ST_GAP  = 2'd3;

    localparam int CNT_W = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(NBITS - 1);
    // With GAP=0 the gap state is never entered, so its terminal count is moot.
    localparam logic [GAP_W-1:0] GAP_LAST = (GAP > 0) ? GAP_W'(GAP - 1) : '0;

    // After the final send cycle either pause in GAP or return straight to IDLE.
    localparam logic [1:0] ST_AFTER_SEND = (GAP > 0) ? ST_GAP : ST_IDLE;

    logic [1:0]       state;
    logic             owner_r;
    logic             last_owner;
    logic [NBITS-1:0] word_reg;
    logic [CNT_W-1:0] bit_cnt;
    logic [GAP_W-1:0] gap_cnt;

    logic             any_req;
    logic             winner;
    logic             last_bit;

    // Arbitration: a lone request wins outright; on a tie the requester that
    // did not win last time goes first. last_owner resets to 1 so that
    // requester 0 takes the very first tie.
    always_comb begin
        any_req = req0 | req1;
        winner  = (req0 & req1) ? ~last_owner : req1;
    end

    assign last_bit = (bit_cnt == BIT_LAST);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= ST_IDLE;
            owner_r    <= 1'b0;
            last_owner <= 1'b1;
            word_reg   <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        word_reg   <= winner ? din1 : din0;
                        owner_r    <= winner;
                        last_owner <= winner;
                        state      <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    bit_cnt <= '0;
                    state   <= ST_SEND;
                end
                ST_SEND: begin
                    if (last_bit) begin
                        gap_cnt <= '0;
                        state   <= ST_AFTER_SEND;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Output decode from registered state only. The shifter samples p2s_din
    // just in LOAD, but it is driven from word_reg continuously.
    assign p2s_din  = word_reg;
    assign p2s_load = (state == ST_LOAD);
    assign p2s_send = (state == ST_SEND);
    assign gnt0     = (state == ST_LOAD) & ~owner_r;
    assign gnt1     = (state == ST_LOAD) &  owner_r;
    assign done     = (state == ST_SEND) & last_bit;
    assign busy     = (state != ST_IDLE);
    assign owner    = owner_r;

endmodule

// File: tb/tb_p2s_arb_ctrl.sv
// ----------------------------------------------------------------------------
// tb_p2s_arb_ctrl
//
// Three instances of p2s_arb_ctrl: defaults (4/1), and the sweep points
// NBITS=1/GAP=0 and NBITS=8/GAP=3. A behavioural shifter per instance turns
// the load/send strobes into a serial bit. Expected grants (instance,
// requester, word) are queued when stimulus is driven and popped at each
// LOAD; the popped word then predicts every serial bit of that transfer.
// ----------------------------------------------------------------------------
module tb_p2s_arb_ctrl;

    typedef struct {
        int         inst;
        int         id;
        logic [7:0] word;
    } exp_t;

    logic       clk = 1'b0;
    logic       n_rst = 1'b1;
    logic       req0_a [3];
    logic       req1_a [3];
    logic [7:0] din0_a [3];
    logic [7:0] din1_a [3];
    wire        gnt0_a [3];
    wire        gnt1_a [3];
    wire        load_a [3];
    wire        send_a [3];
    wire        owner_a [3];
    wire        busy_a [3];
    wire        done_a [3];
    wire  [7:0] pdin_a [3];

    int         n_chk = 0;
    int         n_fail = 0;
    int         cyc = 0;

    exp_t       exp_q [$];
    logic [7:0] sh [3];
    logic [7:0] cur_word [3];
    int         bitk [3];
    int         send_cnt [3];
    int         done_cnt [3];
    int         last_load [3];
    int         gapc [3];
    int         period_from [3];

    function automatic int nb_of(input int g);
        return (g == 0) ? 4 : ((g == 1) ? 1 : 8);
    endfunction

    function automatic int gp_of(input int g);
        return (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int NBV = (g == 0) ? 4 : ((g == 1) ? 1 : 8);
        localparam int GPV = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
        wire [NBV-1:0] pdin;

        p2s_arb_ctrl #(.NBITS(NBV), .GAP(GPV)) u_dut (
            .clk      (clk),
            .n_rst    (n_rst),
            .req0     (req0_a[g]),
            .din0     (din0_a[g][NBV-1:0]),
            .req1     (req1_a[g]),
            .din1     (din1_a[g][NBV-1:0]),
            .gnt0     (gnt0_a[g]),
            .gnt1     (gnt1_a[g]),
            .p2s_din  (pdin),
            .p2s_load (load_a[g]),
            .p2s_send (send_a[g]),
            .owner    (owner_a[g]),
            .busy     (busy_a[g]),
            .done     (done_a[g])
        );

        assign pdin_a[g] = 8'(pdin);
    end

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [6:0] outs_of(input int g);
        return {gnt0_a[g], gnt1_a[g], load_a[g], send_a[g], busy_a[g], done_a[g], owner_a[g]};
    endfunction

    // Behavioural shifter: load captures the word, send shifts right, so the
    // serial output (bit 0) carries word bit k during send cycle k.
    initial forever begin
        @(posedge clk or negedge n_rst);
        for (int g = 0; g < 3; g++) begin
            if (!n_rst)         sh[g] = 8'h00;
            else if (load_a[g]) sh[g] = pdin_a[g];
            else if (send_a[g]) sh[g] = sh[g] >> 1;
        end
    end

    task automatic mon(input int g);
        exp_t e;
        int   nb;
        int   gp;
        nb = nb_of(g);
        gp = gp_of(g);
        check("gnt_excl", 64'(gnt0_a[g] & gnt1_a[g]), 64'd0);
        check("strobe_excl", 64'(load_a[g] & send_a[g]), 64'd0);
        if (load_a[g]) begin
            check("load_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("load_inst", 64'(g), 64'(e.inst));
                check("gnt_pair", 64'({gnt1_a[g], gnt0_a[g]}), (e.id != 0) ? 64'd2 : 64'd1);
                check("owner", 64'(owner_a[g]), 64'(e.id));
                check("load_word", 64'(pdin_a[g]), 64'(e.word));
                cur_word[g] = e.word;
            end
            check("busy_load", 64'(busy_a[g]), 64'd1);
            if (last_load[g] >= period_from[g])
                check("period", 64'(cyc - last_load[g]), 64'(nb + 2 + gp));
            last_load[g] = cyc;
            bitk[g] = 0;
        end else begin
            check("gnt_outside_load", 64'({gnt1_a[g], gnt0_a[g]}), 64'd0);
        end
        if (send_a[g]) begin
            if (bitk[g] < 8)
                check("serial_bit", 64'(sh[g][0]), 64'(cur_word[g][bitk[g]]));
            check("done_pos", 64'(done_a[g]), 64'(bitk[g] == nb - 1));
            check("busy_send", 64'(busy_a[g]), 64'd1);
            bitk[g] = bitk[g] + 1;
            send_cnt[g] = send_cnt[g] + 1;
        end else begin
            check("done_outside_send", 64'(done_a[g]), 64'd0);
        end
        if (gapc[g] > 0) begin
            if (gapc[g] <= gp) begin
                check("gap_strobes", 64'({load_a[g], send_a[g]}), 64'd0);
                check("gap_busy", 64'(busy_a[g]), 64'd1);
                gapc[g] = gapc[g] + 1;
            end else begin
                check("idle_after_gap", 64'(busy_a[g]), 64'd0);
                gapc[g] = 0;
            end
        end
        if (done_a[g]) begin
            done_cnt[g] = done_cnt[g] + 1;
            gapc[g] = 1;
        end
    endtask

    initial begin
        for (int g = 0; g < 3; g++) begin
            bitk[g] = 0; send_cnt[g] = 0; done_cnt[g] = 0;
            last_load[g] = -1000; gapc[g] = 0; cur_word[g] = 8'h00;
        end
        forever begin
            @(negedge clk);
            if (n_rst)
                for (int g = 0; g < 3; g++) mon(g);
        end
    end

    task automatic push_exp(input int g, input int id, input logic [7:0] w);
        exp_q.push_back('{g, id, w});
    endtask

    task automatic set_req(input int g, input int id, input logic v, input logic [7:0] w);
        if (id != 0) begin
            req1_a[g] = v;
            if (v) din1_a[g] = w;
        end else begin
            req0_a[g] = v;
            if (v) din0_a[g] = w;
        end
    endtask

    // Requester: raises req with word k, holds it until its grant, drops it,
    // and re-requests one cycle later while words remain.
    task automatic run_req(input int g, input int id, input int n, input logic [63:0] words,
                           input int dly);
        int t;
        repeat (dly) @(negedge clk);
        for (int k = 0; k < n; k++) begin
            if (k > 0) @(negedge clk);
            set_req(g, id, 1'b1, words[8*k +: 8]);
            t = 0;
            do begin
                @(negedge clk);
                t = t + 1;
            end while (!((id != 0) ? gnt1_a[g] : gnt0_a[g]) && t < 300);
            check("gnt_seen", 64'((id != 0) ? gnt1_a[g] : gnt0_a[g]), 64'd1);
            set_req(g, id, 1'b0, 8'h00);
        end
    endtask

    task automatic drain(input int g);
        int t = 0;
        while ((exp_q.size() != 0 || busy_a[g]) && t < 400) begin
            @(negedge clk);
            t = t + 1;
        end
        check("drain_queue", 64'(exp_q.size()), 64'd0);
        check("drain_idle", 64'(busy_a[g]), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int d0;
        int t;
        for (int g = 0; g < 3; g++) begin
            req0_a[g] = 1'b0; req1_a[g] = 1'b0;
            din0_a[g] = 8'h00; din1_a[g] = 8'h00;
            period_from[g] = 0;
        end
        #2 n_rst = 1'b0;
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            check("reset_outs", 64'(outs_of(g)), 64'd0);
            check("reset_din", 64'(pdin_a[g]), 64'd0);
        end
        n_rst = 1'b1;

        // Simultaneous first requests: requester 0 takes the first tie.
        period_from[0] = cyc; s0 = send_cnt[0]; d0 = done_cnt[0];
        push_exp(0, 0, 8'h3);
        push_exp(0, 1, 8'hC);
        fork
            run_req(0, 0, 1, 64'h3, 0);
            run_req(0, 1, 1, 64'hC, 0);
        join
        drain(0);
        check("tie_sends", 64'(send_cnt[0] - s0), 64'd8);
        check("tie_dones", 64'(done_cnt[0] - d0), 64'd2);

        // Round-robin fairness: 6 words, both always re-requesting.
        period_from[0] = cyc; s0 = send_cnt[0]; d0 = done_cnt[0];
        push_exp(0, 0, 8'h1); push_exp(0, 1, 8'h9);
        push_exp(0, 0, 8'h2); push_exp(0, 1, 8'hA);
        push_exp(0, 0, 8'h3); push_exp(0, 1, 8'hB);
        fork
            run_req(0, 0, 3, 64'h030201, 0);
            run_req(0, 1, 3, 64'h0B0A09, 0);
        join
        drain(0);
        check("rr_sends", 64'(send_cnt[0] - s0), 64'd24);
        check("rr_dones", 64'(done_cnt[0] - d0), 64'd6);

        // Single request: 4'b1011 leaves as 1,1,0,1.
        period_from[0] = cyc; s0 = send_cnt[0]; d0 = done_cnt[0];
        push_exp(0, 0, 8'hB);
        run_req(0, 0, 1, 64'hB, 0);
        drain(0);
        check("single_sends", 64'(send_cnt[0] - s0), 64'd4);
        check("single_dones", 64'(done_cnt[0] - d0), 64'd1);

        // Late request: req1 rises in the second send cycle of a req0 word.
        period_from[0] = cyc; s0 = send_cnt[0];
        push_exp(0, 0, 8'h5);
        push_exp(0, 1, 8'hE);
        fork
            run_req(0, 0, 1, 64'h5, 0);
            run_req(0, 1, 1, 64'hE, 3);
        join
        drain(0);
        check("late_sends", 64'(send_cnt[0] - s0), 64'd8);

        // Reset during the second send cycle abandons the word.
        period_from[0] = cyc; s0 = send_cnt[0]; d0 = done_cnt[0];
        push_exp(0, 0, 8'h6);
        set_req(0, 0, 1'b1, 8'h6);
        t = 0;
        do begin
            @(negedge clk);
            t = t + 1;
        end while (!gnt0_a[0] && t < 50);
        check("midrst_gnt", 64'(gnt0_a[0]), 64'd1);
        set_req(0, 0, 1'b0, 8'h00);
        @(negedge clk);
        @(negedge clk);
        #2 n_rst = 1'b0;
        #1;
        check("midrst_outs", 64'(outs_of(0)), 64'd0);
        check("midrst_din", 64'(pdin_a[0]), 64'd0);
        @(negedge clk);
        check("midrst_hold", 64'(outs_of(0)), 64'd0);
        n_rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_rst_idle", 64'(busy_a[0]), 64'd0);
        end
        check("midrst_sends", 64'(send_cnt[0] - s0), 64'd2);
        check("midrst_no_done", 64'(done_cnt[0] - d0), 64'd0);

        // First tie after reset goes to requester 0 again.
        period_from[0] = cyc;
        push_exp(0, 0, 8'h7);
        push_exp(0, 1, 8'h8);
        fork
            run_req(0, 0, 1, 64'h7, 0);
            run_req(0, 1, 1, 64'h8, 0);
        join
        drain(0);

        // Sweep NBITS=1, GAP=0.
        period_from[1] = cyc; s0 = send_cnt[1]; d0 = done_cnt[1];
        push_exp(1, 0, 8'h1); push_exp(1, 1, 8'h0);
        push_exp(1, 0, 8'h0); push_exp(1, 1, 8'h1);
        fork
            run_req(1, 0, 2, 64'h0001, 0);
            run_req(1, 1, 2, 64'h0100, 0);
        join
        drain(1);
        check("nb1_sends", 64'(send_cnt[1] - s0), 64'd4);
        check("nb1_dones", 64'(done_cnt[1] - d0), 64'd4);

        // Sweep NBITS=8, GAP=3.
        period_from[2] = cyc; s0 = send_cnt[2]; d0 = done_cnt[2];
        push_exp(2, 0, 8'hA5); push_exp(2, 1, 8'h81);
        push_exp(2, 0, 8'h3C); push_exp(2, 1, 8'h7E);
        fork
            run_req(2, 0, 2, 64'h3CA5, 0);
            run_req(2, 1, 2, 64'h7E81, 0);
        join
        drain(2);
        check("nb8_sends", 64'(send_cnt[2] - s0), 64'd32);
        check("nb8_dones", 64'(done_cnt[2] - d0), 64'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
